// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers of
// the MIPS execute stage. It decodes the same 5-bit alucontrol code as the ALU
// and acts only on MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//
// Multiply is radix-2 shift-add and divide is restoring, one bit per RUN
// cycle. Signed operands are reduced to magnitudes on entry and the sign is
// restored in the FIX cycle.
//
// Optional build macro:
//   MULDIV_FAST_MULT_EN  MULT/MULTU use a single-cycle 32x32 multiplier and go
//                        straight from IDLE to FIX. Divide is unaffected.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       operation valid this cycle
//   alucontrol  operation code from the ALU decoder
//   a           rs operand (dividend / multiplicand / MTHI-MTLO source)
//   b           rt operand (divisor / multiplier)
//   busy        iterative operation in flight; upstream stalls on this
//   done        one-cycle pulse when MULT/MULTU/DIV/DIVU has written HI/LO
//   hi, lo      architectural HI and LO registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int ITER_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [4:0]  alucontrol,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] OP_MULTU = 5'b00111;
    localparam logic [4:0] OP_MULT  = 5'b01000;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MTHI  = 5'b10001;
    localparam logic [4:0] OP_MTLO  = 5'b10010;

    localparam int            CW        = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(ITER_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          op_div;     // latched: 1 = divide, 0 = multiply
    logic          op_signed;  // latched: MULT / DIV
    logic          sign_a;
    logic          sign_b;
    logic          div_zero;
    logic [31:0]   a_raw;      // original dividend, returned in HI on divide by zero
    logic [31:0]   opnd;       // multiplicand magnitude or divisor magnitude
    // Working register: multiply = {partial product, remaining multiplier bits},
    // divide = {partial remainder, dividend bits shifting into quotient}.
    logic [63:0]   acc;

    // ------------------------------------------------------------------
    // Decode and operand magnitudes
    // ------------------------------------------------------------------
    logic        is_mul;
    logic        is_div;
    logic        is_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    always_comb begin
        // NOTE: every always_comb output is assigned on every path so no latch is inferred.
        is_mul    = (alucontrol == OP_MULT) || (alucontrol == OP_MULTU);
        is_div    = (alucontrol == OP_DIV)  || (alucontrol == OP_DIVU);
        is_signed = (alucontrol == OP_MULT) || (alucontrol == OP_DIV);
        // Two's-complement negate wraps, so 0x80000000 stays 0x80000000,
        // which is its correct unsigned magnitude.
        mag_a     = (is_signed && a[31]) ? (~a + 32'd1) : a;
        mag_b     = (is_signed && b[31]) ? (~b + 32'd1) : b;
    end

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [63:0] step_next;

    always_comb begin
        // Shift-add: add the multiplicand into the upper half when the
        // current multiplier LSB is set, then shift the whole pair right.
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
        // Restoring divide: the shifted partial remainder is acc[63:31];
        // it never needs more than 33 bits because remainder < divisor.
        div_trial = acc[63:31] - {1'b0, opnd};
        if (!op_div) begin
            step_next = {mul_sum, acc[31:1]};
        end else if (div_trial[32]) begin
            step_next = {acc[62:0], 1'b0};
        end else begin
            step_next = {div_trial[31:0], acc[30:0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction applied in FIX
    // ------------------------------------------------------------------
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] hi_fix;
    logic [31:0] lo_fix;

    always_comb begin
        prod_fix = (op_signed && (sign_a ^ sign_b)) ? (~acc + 64'd1) : acc;
        quo_fix  = (op_signed && (sign_a ^ sign_b)) ? (~acc[31:0] + 32'd1) : acc[31:0];
        // Remainder follows the dividend's sign.
        rem_fix  = (op_signed && sign_a) ? (~acc[63:32] + 32'd1) : acc[63:32];
        if (div_zero) begin
            hi_fix = a_raw;
            lo_fix = 32'hFFFF_FFFF;
        end else if (op_div) begin
            hi_fix = rem_fix;
            lo_fix = quo_fix;
        end else begin
            hi_fix = prod_fix[63:32];
            lo_fix = prod_fix[31:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and registers
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: datapath registers are reset too; the block is small and a
            // reset mid-operation must leave nothing half-written.
            state     <= IDLE;
            count     <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            a_raw     <= '0;
            opnd      <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (alucontrol == OP_MTHI) begin
                            hi <= a;
                        end else if (alucontrol == OP_MTLO) begin
                            lo <= a;
                        end else if (is_mul || is_div) begin
                            op_div    <= is_div;
                            op_signed <= is_signed;
                            sign_a    <= a[31];
                            sign_b    <= b[31];
                            div_zero  <= is_div && (b == 32'd0);
                            a_raw     <= a;
                            opnd      <= is_div ? mag_b : mag_a;
                            count     <= '0;
                            busy      <= 1'b1;
                            if (is_div) begin
                                acc   <= {32'd0, mag_a};
                                state <= RUN;
                            end else begin
`ifdef MULDIV_FAST_MULT_EN
                                acc   <= 64'(mag_a) * 64'(mag_b);
                                state <= FIX;
`else
                                acc   <= {32'd0, mag_b};
                                state <= RUN;
`endif
                            end
                        end
                    end
                end
                RUN: begin
                    acc   <= step_next;
                    count <= count + CW'(1);
                    if (count == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi    <= hi_fix;
                    lo    <= lo_fix;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
